fetch_unit_bp: RTL and testbench

- Parametrised instruction-fetch stage with a 2-bit saturating branch-history table (BHT), valid/ready output handshake, and a mispredict redirect path.
- Sits between instruction memory (combinational read) and the decode stage. Consumes branch-resolution feedback from the execute stage.
- Successor to the single-entry 1-bit-predictor fetch stage. Adds configurable width and depth, true backpressure, counter hysteresis and a mispredict statistics counter.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_bht.sv | 39 +++
 rtl/fetch_unit_bp.sv | 128 ++++++++++++
 tb/tb_fetch_unit_bp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared opcodes, branch-history counter encodings and fetch FSM states
// for the branch-predicting fetch stage.
package fetch_pkg;

   localparam logic [7:0] OPC_JMP = 8'h20;
   localparam logic [7:0] OPC_BCC = 8'h21;

   localparam logic [1:0] CNT_SNT = 2'd0;
   localparam logic [1:0] CNT_WNT = 2'd1;
   localparam logic [1:0] CNT_WT  = 2'd2;
   localparam logic [1:0] CNT_ST  = 2'd3;

   typedef enum logic {S_BOOT, S_RUN} state_e;

   // Saturating 2-bit hysteresis step toward the resolved outcome.
   function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
      else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch-history table: array of 2-bit saturating counters with a
// combinational read port and a synchronous update port (no read bypass).
module fetch_bht
   import fetch_pkg::*;
#(
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   logic [1:0] cnt_q [ENTRIES];
   logic [1:0] cnt_d [ENTRIES];

   // NOTE: every signal written here gets a default first, otherwise the tool infers a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (upd_en) cnt_d[upd_idx] = cnt_step(cnt_q[upd_idx], upd_taken);
   end

   // NOTE: this array is reset like ordinary flops because predictions must be
   // deterministic right after reset; that rules out mapping it to a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/fetch_unit_bp.sv
// Instruction-fetch stage with BHT prediction, valid/ready output register
// and a mispredict redirect path that overrides advance and stall.
module fetch_unit_bp
   import fetch_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int INSTR_W     = 32,
   parameter int PC_STEP     = 2,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               out_pred_taken,
   output logic [ADDR_W-1:0]  out_alt_pc,
   input  logic               res_valid,
   input  logic [ADDR_W-1:0]  res_pc,
   input  logic               res_taken,
   input  logic               res_mispredict,
   input  logic [ADDR_W-1:0]  res_redirect_pc,
   output logic               flush,
   output logic [CNT_W-1:0]   mispredict_cnt
);

   localparam int               STEP_SH = $clog2(PC_STEP);
   localparam int               IDX_W   = $clog2(BHT_ENTRIES);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 out_valid_q, out_valid_d;
   logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
   logic [ADDR_W-1:0]    out_pc_q, out_pc_d;
   logic                 out_pred_q, out_pred_d;
   logic [ADDR_W-1:0]    out_alt_q, out_alt_d;
   logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

   logic [7:0]           opcode;
   logic                 is_jmp, is_bcc, pred_taken, adv;
   logic [ADDR_W-1:0]    jmp_tgt, bcc_tgt, pc_seq;
   logic [1:0]           bht_cnt;
   logic                 unused_bits;

   assign opcode     = imem_data[INSTR_W-1 -: 8];
   assign is_jmp     = (opcode == OPC_JMP);
   assign is_bcc     = (opcode == OPC_BCC);
   assign jmp_tgt    = imem_data[ADDR_W+15:16];
   assign bcc_tgt    = imem_data[ADDR_W-1:0];
   assign pc_seq     = pc_q + STEP;
   assign pred_taken = is_bcc && (bht_cnt >= CNT_WT);
   assign adv        = (state_q == S_RUN) && (!out_valid_q || out_ready);
   assign flush      = res_valid && res_mispredict;
   assign unused_bits = ^{imem_data, res_pc};

   fetch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc_q[STEP_SH +: IDX_W]),
      .rd_cnt    (bht_cnt),
      .upd_en    (res_valid),
      .upd_idx   (res_pc[STEP_SH +: IDX_W]),
      .upd_taken (res_taken)
   );

   always_comb begin
      state_d     = S_RUN;   // boot lasts exactly one cycle
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      out_pred_d  = out_pred_q;
      out_alt_d   = out_alt_q;
      miss_cnt_d  = miss_cnt_q;

      if (flush) begin
         pc_d        = res_redirect_pc;
         out_valid_d = 1'b0;
         if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end else if (adv) begin
         out_valid_d = 1'b1;
         out_instr_d = imem_data;
         out_pc_d    = pc_q;
         out_pred_d  = pred_taken;
         out_alt_d   = pred_taken ? pc_seq : bcc_tgt;
         if (is_jmp)          pc_d = jmp_tgt;
         else if (pred_taken) pc_d = bcc_tgt;
         else                 pc_d = pc_seq;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_BOOT;
         pc_q        <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_pred_q  <= 1'b0;
         out_alt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_pred_q  <= out_pred_d;
         out_alt_q   <= out_alt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign imem_addr      = pc_q;
   assign out_valid      = out_valid_q;
   assign out_instr      = out_instr_q;
   assign out_pc         = out_pc_q;
   assign out_pred_taken = out_pred_q;
   assign out_alt_pc     = out_alt_q;
   assign mispredict_cnt = miss_cnt_q;

endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed plus randomized bench for fetch_unit_bp against a behavioural
// fetch/predict model built from integer arithmetic over an instruction image.
module tb_fetch_unit_bp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic        out_pred_taken;
   logic [7:0]  out_alt_pc;
   logic        res_valid = 1'b0;
   logic [7:0]  res_pc = '0;
   logic        res_taken = 1'b0;
   logic        res_mispredict = 1'b0;
   logic [7:0]  res_redirect_pc = '0;
   logic        flush;
   logic [15:0] mispredict_cnt;

   logic [31:0] mem [256];
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   fetch_unit_bp dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_pred_taken  (out_pred_taken),
      .out_alt_pc      (out_alt_pc),
      .res_valid       (res_valid),
      .res_pc          (res_pc),
      .res_taken       (res_taken),
      .res_mispredict  (res_mispredict),
      .res_redirect_pc (res_redirect_pc),
      .flush           (flush),
      .mispredict_cnt  (mispredict_cnt)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state: what the decode stage should see.
   int          m_boot, m_pc, m_ov, m_opc, m_pred, m_alt, m_cnt;
   logic [31:0] m_instr;
   int          m_bht [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_boot = 1; m_pc = 0; m_ov = 0; m_opc = 0; m_pred = 0; m_alt = 0; m_cnt = 0;
      m_instr = '0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", out_valid, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_pred", out_pred_taken, 0);
      check("rst_out_alt", out_alt_pc, 0);
      check("rst_miss_cnt", mispredict_cnt, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check_reset_values();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One clock: predict the model's next state from current inputs, clock, compare.
   task automatic step();
      logic [31:0] ins;
      int op, pred, fl, k;
      #1;
      ins = mem[m_pc];
      op  = ins[31:24];
      fl  = (res_valid && res_mispredict) ? 1 : 0;
      check("imem_addr_pre", imem_addr, m_pc);
      check("flush", flush, fl);
      pred = (op == 'h21 && m_bht[(m_pc >> 1) & 15] >= 2) ? 1 : 0;
      if (fl != 0) begin
         m_pc = res_redirect_pc;
         m_ov = 0;
         if (m_cnt < 65535) m_cnt++;
      end else if (m_boot == 0 && (m_ov == 0 || out_ready)) begin
         m_ov = 1; m_instr = ins; m_opc = m_pc; m_pred = pred;
         m_alt = (pred != 0) ? ((m_pc + 2) & 255) : ins[7:0];
         if (op == 'h20)     m_pc = ins[23:16];
         else if (pred != 0) m_pc = ins[7:0];
         else                m_pc = (m_pc + 2) & 255;
      end
      m_boot = 0;
      if (res_valid) begin
         k = (res_pc >> 1) & 15;
         if (res_taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
         else           m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
      end
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_ov);
      check("imem_addr", imem_addr, m_pc);
      check("miss_cnt", mispredict_cnt, m_cnt);
      if (m_ov != 0) begin
         check("out_pc", out_pc, m_opc);
         check("out_instr", out_instr, m_instr);
         check("out_pred", out_pred_taken, m_pred);
         if (m_instr[31:24] == 8'h21) check("out_alt", out_alt_pc, m_alt);
      end
   endtask

   task automatic wait_out(input logic [7:0] a, input int max);
      int found;
      found = 0;
      for (int i = 0; i < max && found == 0; i++) begin
         step();
         if (m_ov != 0 && m_opc == a) found = 1;
      end
      if (found == 0) begin
         n_vec++;
         n_fail++;
         $error("FAIL wait_out_%0h: not delivered within %0d cycles", a, max);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int r;
      w = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0)      w[31:24] = 8'h20;
      else if (r == 1) w[31:24] = 8'h21;
      else if (w[31:24] == 8'h20 || w[31:24] == 8'h21) w[31:24] = 8'h00;
      return w;
   endfunction

   initial begin
      int prev;

      // Sequential code, stall hold and address wrap.
      for (int a = 0; a < 256; a++) mem[a] = {8'h01, 16'h0000, 8'(a)};
      do_reset();
      step();
      check("boot_out_valid", out_valid, 0);
      step();
      check("first_valid", out_valid, 1);
      check("first_pc", out_pc, 0);
      wait_out(8'h10, 20);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", out_pc, 8'h10);
         check("stall_instr", out_instr, mem[8'h10]);
         check("stall_imem_addr", imem_addr, 8'h12);
      end
      out_ready = 1'b1;
      step();
      check("after_stall_pc", out_pc, 8'h12);
      for (int i = 0; i < 140; i++) begin
         prev = m_opc;
         step();
         if (prev == 'hFE) check("wrap_pc", out_pc, 8'h00);
      end

      // Jump, conditional branch training, mispredict under stall.
      mem[8'h08] = 32'h2040_0000;
      mem[8'h48] = 32'h2020_0000;
      mem[8'h20] = 32'h2100_0030;
      mem[8'h2A] = 32'h2020_0000;
      do_reset();
      wait_out(8'h08, 20);
      check("jmp_imem_addr", imem_addr, 8'h40);
      check("jmp_pred", out_pred_taken, 0);
      wait_out(8'h20, 30);
      check("bcc_fresh_pred", out_pred_taken, 0);
      check("bcc_fresh_alt", out_alt_pc, 8'h30);
      res_valid = 1'b1; res_taken = 1'b1; res_mispredict = 1'b0; res_pc = 8'h20;
      step();
      step();
      res_valid = 1'b0;
      wait_out(8'h20, 20);
      check("bcc_trained_pred", out_pred_taken, 1);
      check("bcc_trained_alt", out_alt_pc, 8'h22);
      out_ready = 1'b0;
      res_valid = 1'b1; res_mispredict = 1'b1; res_redirect_pc = 8'h50; res_pc = 8'h20; res_taken = 1'b0;
      #1 check("flush_same_cycle", flush, 1);
      step();
      check("flush_next_valid", out_valid, 0);
      res_valid = 1'b0; res_mispredict = 1'b0;
      out_ready = 1'b1;
      step();
      check("redirect_valid", out_valid, 1);
      check("redirect_pc", out_pc, 8'h50);
      check("redirect_cnt", mispredict_cnt, 1);

      // Asynchronous reset landing on a flush cycle.
      res_valid = 1'b1; res_mispredict = 1'b1; res_redirect_pc = 8'h70;
      #2 rst = 1'b1;
      #1 check_reset_values();
      res_valid = 1'b0; res_mispredict = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      check("reboot_valid", out_valid, 0);
      wait_out(8'h20, 30);
      check("reboot_bht_pred", out_pred_taken, 0);
      check("reboot_bht_alt", out_alt_pc, 8'h30);

      // Random program image, backpressure and resolution traffic.
      for (int a = 0; a < 256; a++) mem[a] = rand_instr();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         out_ready       = ($urandom_range(0, 3) != 0);
         res_valid       = ($urandom_range(0, 2) == 0);
         res_pc          = 8'($urandom);
         res_taken       = 1'($urandom);
         res_mispredict  = ($urandom_range(0, 5) == 0);
         res_redirect_pc = 8'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
